xy_mod_ctrl: RTL and testbench

XY_MOD_CTRL -- requirements
Module: xy_mod_ctrl

---
 rtl/xy_mod_pkg.sv | 36 +++
 rtl/xy_mod_divider.sv | 70 +++++++
 rtl/xy_mod_ctrl.sv | 133 +++++++++++++
 tb/tb_xy_mod_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xy_mod_pkg.sv
// Shared types and constants for the X mod (X - Y) controller.
// Optional IRQ output is enabled with the XY_MOD_IRQ_EN macro (see xy_mod_ctrl).
package xy_mod_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned OUT_W  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [ADDR_W-1:0] ADDR_X       = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_Y       = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_RES_CMD = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_STATUS  = 2'd3;

    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_DONE = 1;
    localparam int unsigned STAT_ERR  = 2;

    // Assemble the STATUS read word; unused upper bits read as zero.
    function automatic logic [OUT_W-1:0] pack_status(input logic busy,
                                                     input logic done,
                                                     input logic err);
        logic [OUT_W-1:0] s;
        s            = '0;
        s[STAT_BUSY] = busy;
        s[STAT_DONE] = done;
        s[STAT_ERR]  = err;
        return s;
    endfunction

endpackage

// File: rtl/xy_mod_divider.sv
// Iterative restoring divider: one MSB-first shift-subtract step per cycle,
// WIDTH steps per operation, remainder output only.
module xy_mod_divider #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             valid_q;
    logic [WIDTH:0]   part_c;

    // One restoring step: shift in next dividend bit, subtract if it fits.
    always_comb begin
        part_c = {rem_q, quo_q[WIDTH-1]};
        rem_d  = part_c[WIDTH-1:0];
        quo_d  = {quo_q[WIDTH-2:0], 1'b0};
        if (part_c >= {1'b0, div_q}) begin
            rem_d = WIDTH'(part_c - {1'b0, div_q});
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    // Operand load on start, then WIDTH steps; valid pulses after the last one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (start_i) begin
                rem_q  <= '0;
                quo_q  <= dividend_i;
                div_q  <= divisor_i;
                cnt_q  <= CNT_W'(WIDTH);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rem_q <= rem_d;
                quo_q <= quo_d;
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    busy_q  <= 1'b0;
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o      = busy_q;
    assign valid_o     = valid_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/xy_mod_ctrl.sv
// Register-mapped controller computing RESULT = X mod ((X - Y) mod 2^WIDTH).
// Define XY_MOD_IRQ_EN to add a one-cycle IRQ pulse when DONE becomes set.
module xy_mod_ctrl
    import xy_mod_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              E,
    input  logic              W,
    input  logic              R,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [WIDTH-1:0]  D,
    output logic [OUT_W-1:0]  OUT
`ifdef XY_MOD_IRQ_EN
    ,
    output logic              IRQ
`endif
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] x_q, y_q, result_q, divisor_q;
    logic [WIDTH-1:0] diff_c, div_rem;
    logic [OUT_W-1:0] out_q, rd_data_c;
    logic             done_q, err_q;
    logic             busy_c, wr_ok_c, start_c, zero_div_c;
    logic             div_start_c, enter_done_c;
    logic             div_busy, div_valid;

    assign busy_c     = (state_q != IDLE);
    assign diff_c     = x_q - y_q;
    assign wr_ok_c    = E & W & ~busy_c;
    assign start_c    = wr_ok_c & (ADDR == ADDR_RES_CMD) & D[0];
    assign zero_div_c = (divisor_q == '0);

    // The divider is launched with the accepted command so its WIDTH steps
    // overlap LOAD and DIV; a zero divisor never starts it and is caught in DIV.
    xy_mod_divider #(.WIDTH(WIDTH)) u_div (
        .clk_i       (CLK),
        .rst_i       (RST),
        .start_i     (div_start_c),
        .dividend_i  (x_q),
        .divisor_i   (diff_c),
        .busy_o      (div_busy),
        .valid_o     (div_valid),
        .remainder_o (div_rem)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and control strobes.
    always_comb begin
        state_d      = state_q;
        div_start_c  = 1'b0;
        enter_done_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_c) begin
                    state_d     = LOAD;
                    div_start_c = (diff_c != '0);
                end
            end
            LOAD: state_d = DIV;
            DIV: begin
                if (zero_div_c || (div_valid && !div_busy)) begin
                    state_d      = DONE;
                    enter_done_c = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read mux over pre-edge register values.
    always_comb begin
        rd_data_c = '0;
        case (ADDR)
            ADDR_X:       rd_data_c = OUT_W'(x_q);
            ADDR_Y:       rd_data_c = OUT_W'(y_q);
            ADDR_RES_CMD: rd_data_c = OUT_W'(result_q);
            ADDR_STATUS:  rd_data_c = pack_status(busy_c, done_q, err_q);
            default:      rd_data_c = '0;
        endcase
    end

    // Operand, result, sticky flag and read-data registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            x_q       <= '0;
            y_q       <= '0;
            result_q  <= '0;
            divisor_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            out_q     <= '0;
        end else begin
            if (wr_ok_c && (ADDR == ADDR_X)) x_q <= D;
            if (wr_ok_c && (ADDR == ADDR_Y)) y_q <= D;
            if (start_c) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end
            if (state_q == LOAD) divisor_q <= diff_c;
            if (enter_done_c) begin
                done_q   <= 1'b1;
                err_q    <= zero_div_c;
                result_q <= zero_div_c ? '0 : div_rem;
            end
            if (E && R) out_q <= rd_data_c;
        end
    end

    assign OUT = out_q;

`ifdef XY_MOD_IRQ_EN
    logic irq_q;

    // One-cycle pulse coincident with DONE being set.
    always_ff @(posedge CLK) begin
        if (RST) irq_q <= 1'b0;
        else     irq_q <= enter_done_c;
    end

    assign IRQ = irq_q;
`endif

endmodule

// File: tb/tb_xy_mod_ctrl.sv
// Directed bench for xy_mod_ctrl; expected read data goes through a scoreboard queue.
module tb_xy_mod_ctrl;

    localparam int unsigned WIDTH = 16;

    logic        clk;
    logic        rst, e, w, r;
    logic [1:0]  addr;
    logic [15:0] d;
    logic [31:0] out;
`ifdef XY_MOD_IRQ_EN
    logic        irq;
    int          irq_cnt = 0;
`endif

    typedef struct {
        logic [31:0] exp;
        string       tag;
    } sb_t;

    sb_t sb_q[$];
    int  n_vec  = 0;
    int  n_err  = 0;
    int  n_comp = 0;

    xy_mod_ctrl #(.WIDTH(WIDTH)) dut (
        .CLK  (clk),
        .RST  (rst),
        .E    (e),
        .W    (w),
        .R    (r),
        .ADDR (addr),
        .D    (d),
        .OUT  (out)
`ifdef XY_MOD_IRQ_EN
        ,
        .IRQ  (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef XY_MOD_IRQ_EN
    always @(negedge clk) if (irq === 1'b1) irq_cnt++;
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] dv;
        dv = x - y;
        if (dv == 16'd0) return 32'd0;
        return 32'(x % dv);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        e = 1'b0; w = 1'b0; r = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] v);
        e = 1'b1; w = 1'b1; r = 1'b0; addr = a; d = v;
        step();
        e = 1'b0; w = 1'b0;
    endtask

    task automatic pop_chk();
        sb_t s;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL sb_underflow: observed 0x%0h expected none", out);
        end else begin
            s = sb_q.pop_front();
            chk(s.tag, out, s.exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        sb_t s;
        s.exp = exp;
        s.tag = tag;
        sb_q.push_back(s);
        e = 1'b1; r = 1'b1; w = 1'b0; addr = a;
        step();
        e = 1'b0; r = 1'b0;
        pop_chk();
    endtask

    // Read STATUS every cycle starting at read index k0; index 1 is the edge after the command edge.
    task automatic poll_done(input int k0, input int exp_k, input string tag);
        int k;
        int irq_k;
        bit found;
        k = k0; irq_k = -1; found = 1'b0;
        while (k <= k0 + 40 && !found) begin
            e = 1'b1; r = 1'b1; w = 1'b0; addr = 2'd3;
            step();
`ifdef XY_MOD_IRQ_EN
            if (irq === 1'b1 && irq_k < 0) irq_k = k;
`endif
            if (out[1] === 1'b1) found = 1'b1;
            else k++;
        end
        e = 1'b0; r = 1'b0;
        chk({tag, "_done_cycle"}, 32'(k), 32'(exp_k));
`ifdef XY_MOD_IRQ_EN
        chk({tag, "_irq_cycle"}, 32'(irq_k), 32'(exp_k - 1));
`endif
        n_comp++;
    endtask

    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input string tag);
        logic [15:0] dv;
        dv = x - y;
        wr(2'd0, x);
        wr(2'd1, y);
        wr(2'd2, 16'h0001);
        poll_done(1, (dv == 16'd0) ? 3 : 18, tag);
        rd(2'd3, (dv == 16'd0) ? 32'h6 : 32'h2, {tag, "_status"});
        rd(2'd2, model(x, y), {tag, "_result"});
    endtask

    initial begin
        logic [15:0] rx, ry;
        rst = 1'b1; e = 1'b0; w = 1'b0; r = 1'b0; addr = 2'd0; d = 16'h0;
        step();
        // Access attempts during reset must be ignored.
        e = 1'b1; w = 1'b1; r = 1'b1; addr = 2'd0; d = 16'h5555;
        step();
        rst = 1'b0; e = 1'b0; w = 1'b0; r = 1'b0;
        chk("reset_out", out, 32'h0);
        rd(2'd0, 32'h0, "reset_x");
        rd(2'd3, 32'h0, "reset_status");
        rd(2'd2, 32'h0, "reset_result");

        // Register readback and OUT hold without a read.
        wr(2'd0, 16'd100);
        wr(2'd1, 16'd93);
        rd(2'd0, 32'd100, "rb_x");
        rd(2'd1, 32'd93, "rb_y");
        idle(2);
        chk("out_hold", out, 32'd93);

        // CMD with D[0]=0 does nothing.
        wr(2'd2, 16'h0002);
        rd(2'd3, 32'h0, "cmd0_noop");

        // 100 mod 7: busy next cycle, done at 18.
        wr(2'd2, 16'h0001);
        rd(2'd3, 32'h1, "busy_next");
        poll_done(2, 18, "x100_y93");
        rd(2'd3, 32'h2, "x100_y93_status");
        rd(2'd2, 32'd2, "x100_y93_result");

        // Zero divisor.
        run_op(16'd5, 16'd5, "err_5_5");

        // Wrapped divisor 65529; RESULT read while busy gives previous result.
        wr(2'd0, 16'd3);
        wr(2'd1, 16'd10);
        wr(2'd2, 16'h0001);
        rd(2'd2, 32'd0, "busy_prev_result");
        poll_done(2, 18, "x3_y10");
        rd(2'd3, 32'h2, "x3_y10_status");
        rd(2'd2, 32'd3, "x3_y10_result");

        // Writes while busy are ignored, completion unchanged.
        wr(2'd0, 16'd100);
        wr(2'd1, 16'd93);
        wr(2'd2, 16'h0001);
        idle(4);
        wr(2'd0, 16'hFFFF);
        wr(2'd2, 16'h0001);
        poll_done(7, 18, "busy_wr");
        rd(2'd3, 32'h2, "busy_wr_status");
        rd(2'd2, 32'd2, "busy_wr_result");
        rd(2'd0, 32'd100, "busy_wr_x");

        // Simultaneous write and read of X returns the old value.
        e = 1'b1; w = 1'b1; r = 1'b1; addr = 2'd0; d = 16'h1234;
        step();
        e = 1'b0; w = 1'b0; r = 1'b0;
        chk("rw_same_addr", out, 32'd100);
        rd(2'd0, 32'h1234, "rw_new_x");

        // Reset mid-computation, then a fresh run.
        wr(2'd0, 16'd100);
        wr(2'd2, 16'h0001);
        idle(7);
        rst = 1'b1; e = 1'b1; w = 1'b1; r = 1'b1; addr = 2'd0; d = 16'hBEEF;
        step();
        rst = 1'b0; e = 1'b0; w = 1'b0; r = 1'b0;
        chk("rst_mid_out", out, 32'h0);
        rd(2'd3, 32'h0, "rst_mid_status");
        rd(2'd2, 32'h0, "rst_mid_result");
        rd(2'd0, 32'h0, "rst_mid_x");
        run_op(16'd100, 16'd93, "after_rst");

        // Boundary operands.
        run_op(16'hFFFF, 16'h0000, "max_div");
        run_op(16'h0000, 16'h0001, "zero_dividend");
        run_op(16'hFFFF, 16'hFFFE, "div_one");
        run_op(16'd1000, 16'd1, "x1000_y1");
        run_op(16'h0001, 16'h0002, "dividend_lt");

        for (int i = 0; i < 4; i++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            run_op(rx, ry, $sformatf("rand%0d", i));
        end

`ifdef XY_MOD_IRQ_EN
        idle(2);
        chk("irq_count", 32'(irq_cnt), 32'(n_comp));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
